// File: rtl/palette_mapper.sv
// palette_mapper: maps luma to 24-bit RGB through run-time-writable palettes,
// with optional blending between adjacent entries; fixed 3-cycle latency.
module palette_mapper #(
    parameter int LUMA_W   = 8,
    parameter int IDX_BITS = 3,
    parameter int PAL_BITS = 4,
    parameter int INTERP   = 1
) (
    input  logic                         pixclk,
    input  logic                         rst,
    input  logic [LUMA_W-1:0]            vid_pData_in,
    input  logic                         de_in,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    input  logic [PAL_BITS-1:0]          mode,
    input  logic                         bypass,
    input  logic                         pal_wr_en,
    input  logic [PAL_BITS+IDX_BITS-1:0] pal_wr_addr,
    input  logic [23:0]                  pal_wr_data,
    output logic [23:0]                  vid_pData_out,
    output logic                         de_out,
    output logic                         hsync_out,
    output logic                         vsync_out
);
    localparam int F  = LUMA_W - IDX_BITS;
    localparam int N  = 1 << IDX_BITS;
    localparam int NP = 1 << PAL_BITS;
    localparam int W  = 9 + F;

    logic [23:0]         pal [NP][N];
    logic [PAL_BITS-1:0] active_mode;
    logic                active_bypass;
    logic [LUMA_W-1:0]   y1;
    logic                de1, hs1, vs1, de2, hs2, vs2, byp2;
    logic [23:0]         a2, b2;
    logic [F-1:0]        f2;
    logic [7:0]          g2;
    logic [IDX_BITS-1:0] idx, idx_n;
    logic [23:0]         a, b, mixed;

    function automatic logic [23:0] ramp(input int k);
        logic [7:0] c;
        c = 8'((k * 255) / (N - 1));
        return {c, c, c};
    endfunction

    // Weights sum to 2^F, so the truncated result never exceeds 255.
    function automatic logic [7:0] mix(input logic [7:0] ca, input logic [7:0] cb, input logic [F-1:0] f);
        logic [W-1:0] s;
        s = W'(ca) * (W'(1 << F) - W'(f)) + W'(cb) * W'(f);
        return s[F+7:F];
    endfunction

    always_comb begin
        idx   = y1[LUMA_W-1:F];
        idx_n = idx + IDX_BITS'(1);
        a     = pal[active_mode][idx];
        b     = (&idx) ? a : pal[active_mode][idx_n];
        mixed = (INTERP != 0) ? {mix(a2[23:16], b2[23:16], f2),
                                 mix(a2[15:8],  b2[15:8],  f2),
                                 mix(a2[7:0],   b2[7:0],   f2)} : a2;
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            for (int p = 0; p < NP; p++)
                for (int k = 0; k < N; k++)
                    pal[p][k] <= ramp(k);
        end else if (pal_wr_en) begin
            pal[pal_wr_addr[PAL_BITS+IDX_BITS-1:IDX_BITS]][pal_wr_addr[IDX_BITS-1:0]] <= pal_wr_data;
        end
    end

    // vs1 doubles as the previous-cycle vsync for edge detection.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            active_mode   <= '0;
            active_bypass <= 1'b0;
            y1            <= '0;
            {de1, hs1, vs1} <= '0;
            {de2, hs2, vs2, byp2} <= '0;
            a2            <= '0;
            b2            <= '0;
            f2            <= '0;
            g2            <= '0;
            vid_pData_out <= '0;
            {de_out, hsync_out, vsync_out} <= '0;
        end else begin
            if (vsync_in && !vs1) begin
                active_mode   <= mode;
                active_bypass <= bypass;
            end
            y1            <= vid_pData_in;
            {de1, hs1, vs1} <= {de_in, hsync_in, vsync_in};
            {de2, hs2, vs2} <= {de1, hs1, vs1};
            byp2          <= active_bypass;
            a2            <= a;
            b2            <= b;
            f2            <= y1[F-1:0];
            g2            <= y1[LUMA_W-1:LUMA_W-8];
            vid_pData_out <= byp2 ? {g2, g2, g2} : mixed;
            {de_out, hsync_out, vsync_out} <= {de2, hs2, vs2};
        end
    end
endmodule
